// File: rtl/algo_1rw1w_t1_bank_resp_pkg.sv
// Shared types, error-bit positions and sizing helper for the t1 bank responder.
// Imported by the interface, the refresh tracker and the top.
package algo_t1_resp_pkg;

  typedef enum logic {
    REF_IDLE = 1'b0,
    REF_BUSY = 1'b1
  } refState_e;

  localparam logic [0:0] ST_IDLE = REF_IDLE;
  localparam logic [0:0] ST_BUSY = REF_BUSY;

  // Bit positions inside the per-cycle protocol-error vector.
  localparam int ERR_RW_BOTH  = 0;
  localparam int ERR_ADDR     = 1;
  localparam int ERR_BUSY_ACC = 2;
  localparam int ERR_REF_BANK = 3;
  localparam int ERR_REF_BUSY = 4;
  localparam int NUM_ERR      = 5;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/algo_1rw1w_t1_bank_resp_if.sv
// t1 port bundle between the 1RW1W algorithm top (master) and one bank responder (slave).
// Requests are single-cycle strobes with no backpressure; rd_vld qualifies t1_doutA/rd_dwsn for one cycle.
interface algo_1rw1w_t1_bank_resp_if #(
  parameter int PHYWDTH = 64,
  parameter int BITSROW = 11,
  parameter int BITRBNK = 1,
  parameter int BITDWSN = 2
);
  import algo_t1_resp_pkg::*;

  logic               t1_readA;
  logic               t1_writeA;
  logic [BITSROW-1:0] t1_addrA;
  logic [PHYWDTH-1:0] t1_dinA;
  logic [PHYWDTH-1:0] t1_bwA;
  logic [BITDWSN-1:0] t1_dwsnA;
  logic [PHYWDTH-1:0] t1_doutA;
  logic               t1_refrB;
  logic [BITRBNK-1:0] t1_bankB;
  logic               rd_vld;
  logic [BITDWSN-1:0] rd_dwsn;
  logic               cmd_err;
  logic               ref_err;

  modport master (
    output t1_readA, t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_dwsnA, t1_refrB, t1_bankB,
    input  t1_doutA, rd_vld, rd_dwsn, cmd_err, ref_err
  );

  modport slave (
    input  t1_readA, t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_dwsnA, t1_refrB, t1_bankB,
    output t1_doutA, rd_vld, rd_dwsn, cmd_err, ref_err
  );

endinterface

// File: rtl/algo_1rw1w_t1_bank_resp_ref_trk.sv
// Per-sub-bank refresh tracker: busy window after a refresh and a saturating starvation count.
module algo_t1_ref_trk
  import algo_t1_resp_pkg::*;
#(
  parameter int REFDLY = 2,
  parameter int REFWIN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr,
  output logic       busy,
  output logic       starved,
  output logic [0:0] state
);

  localparam int BW = clog2(REFDLY + 1);
  localparam int SW = clog2(REFWIN + 1);

  logic [BW-1:0] busyCnt;
  logic [SW-1:0] starvCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busyCnt  <= '0;
      starvCnt <= '0;
    end else if (refr) begin
      state    <= ST_BUSY;
      busyCnt  <= BW'(REFDLY);
      starvCnt <= '0;
    end else begin
      if (busyCnt != '0) busyCnt <= busyCnt - BW'(1);
      // Leave BUSY on the same edge the counter drains to zero.
      if (state == ST_BUSY && busyCnt <= BW'(1)) state <= ST_IDLE;
      if (starvCnt != SW'(REFWIN)) starvCnt <= starvCnt + SW'(1);
    end
  end

  assign busy    = (state == ST_BUSY);
  assign starved = (starvCnt == SW'(REFWIN));

endmodule

// File: rtl/algo_1rw1w_t1_bank_resp.sv
// Memory-side responder for one virtual bank: masked row writes, fixed-latency reads,
// refresh busy/starvation tracking and protocol-violation reporting.
module algo_1rw1w_t1_bank_resp
  import algo_t1_resp_pkg::*;
#(
  parameter int PHYWDTH = 64,
  parameter int NUMSROW = 2048,
  parameter int BITSROW = 11,
  parameter int NUMRBNK = 1,
  parameter int BITRBNK = 1,
  parameter int BITDWSN = 2,
  parameter int DELAY   = 2,
  parameter int REFDLY  = 2,
  parameter int REFWIN  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  algo_1rw1w_t1_bank_resp_if.slave     bus,
  output logic [NUMRBNK-1:0]           refState
);

  localparam logic [BITSROW:0] ROWLIM = (BITSROW + 1)'(NUMSROW);
  localparam logic [BITRBNK:0] RBLIM  = (BITRBNK + 1)'(NUMRBNK);

  logic [PHYWDTH-1:0] mem [NUMSROW];

  logic [BITRBNK-1:0] rb;
  logic               addrOk, bankOk, single, accBusy, refOnBusy, doRead, doWrite;
  logic [NUMRBNK-1:0] refHit, busyVec, starvedVec;
  logic [NUM_ERR-1:0] errVec;

  logic [DELAY-1:0]   vldPipe;
  logic [PHYWDTH-1:0] dataPipe [DELAY];
  logic [BITDWSN-1:0] dwsnPipe [DELAY];
  logic               cmdErr, refErr;

  assign rb     = BITRBNK'(int'(bus.t1_addrA) % NUMRBNK);
  assign addrOk = {1'b0, bus.t1_addrA} < ROWLIM;
  assign bankOk = {1'b0, bus.t1_bankB} < RBLIM;
  assign single = bus.t1_readA ^ bus.t1_writeA;

  // A sub-bank counts as busy in its own refresh cycle as well as in the following window.
  always_comb begin
    refHit    = '0;
    accBusy   = 1'b0;
    refOnBusy = 1'b0;
    for (int i = 0; i < NUMRBNK; i++) begin
      refHit[i] = bus.t1_refrB & bankOk & (bus.t1_bankB == BITRBNK'(i));
      if (rb == BITRBNK'(i)) accBusy = busyVec[i] | refHit[i];
      if (refHit[i] & busyVec[i]) refOnBusy = 1'b1;
    end
  end

  always_comb begin
    errVec               = '0;
    errVec[ERR_RW_BOTH]  = bus.t1_readA & bus.t1_writeA;
    errVec[ERR_ADDR]     = single & ~addrOk;
    errVec[ERR_BUSY_ACC] = single & addrOk & accBusy;
    errVec[ERR_REF_BANK] = bus.t1_refrB & ~bankOk;
    errVec[ERR_REF_BUSY] = refOnBusy;
  end

  assign doRead  = bus.t1_readA & ~bus.t1_writeA & addrOk;
  assign doWrite = bus.t1_writeA & ~bus.t1_readA & addrOk & ~accBusy;

  for (genvar g = 0; g < NUMRBNK; g++) begin : g_trk
    algo_t1_ref_trk #(
      .REFDLY (REFDLY),
      .REFWIN (REFWIN)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .refr    (refHit[g]),
      .busy    (busyVec[g]),
      .starved (starvedVec[g]),
      .state   (refState[g:g])
    );
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[bus.t1_addrA] <= (mem[bus.t1_addrA] & ~bus.t1_bwA) | (bus.t1_dinA & bus.t1_bwA);
  end

  // Data/dwsn stages only advance behind a valid, so the last stage holds the last returned read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vldPipe <= '0;
      for (int k = 0; k < DELAY; k++) begin
        dataPipe[k] <= '0;
        dwsnPipe[k] <= '0;
      end
      cmdErr <= 1'b0;
      refErr <= 1'b0;
    end else begin
      vldPipe[0] <= doRead;
      if (doRead) begin
        dataPipe[0] <= accBusy ? '0 : mem[bus.t1_addrA];
        dwsnPipe[0] <= bus.t1_dwsnA;
      end
      for (int k = 1; k < DELAY; k++) begin
        vldPipe[k] <= vldPipe[k-1];
        if (vldPipe[k-1]) begin
          dataPipe[k] <= dataPipe[k-1];
          dwsnPipe[k] <= dwsnPipe[k-1];
        end
      end
      cmdErr <= |errVec;
      refErr <= refErr | (|starvedVec);
    end
  end

  assign bus.t1_doutA = dataPipe[DELAY-1];
  assign bus.rd_vld   = vldPipe[DELAY-1];
  assign bus.rd_dwsn  = dwsnPipe[DELAY-1];
  assign bus.cmd_err  = cmdErr;
  assign bus.ref_err  = refErr;

endmodule

// File: tb/tb_algo_1rw1w_t1_bank_resp.sv
// Directed bench for the t1 bank responder: a vector table for the per-cycle behaviour and
// hand-written sequences for refresh busy windows, reset with reads in flight and starvation.
module tb_algo_1rw1w_t1_bank_resp;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [63:0] din;
    logic [63:0] bw;
    logic [1:0]  dwsn;
    logic        refr;
    logic        bank;
    logic        expVld;
    logic [63:0] expDout;
    logic [1:0]  expDwsn;
    logic        expErr;
  } vec_t;

  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] VA = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] VB = 64'hFFFF_0000_FFFF_00AB;
  localparam logic [63:0] VC = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] VD = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] VE = 64'h0020_4060_0000_CDEF;

  logic       clk;
  logic       rst_n;
  logic [0:0] refState;
  int         checks;
  int         errors;
  logic [63:0] exp_q[$];
  vec_t       vecs[$];

  algo_1rw1w_t1_bank_resp_if bus ();

  algo_1rw1w_t1_bank_resp dut (
    .clk      (clk),
    .rst      (rst_n),
    .bus      (bus),
    .refState (refState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic [10:0] addr,
                              input logic [63:0] din, input logic [63:0] bw, input logic [1:0] dwsn,
                              input logic refr, input logic bank, input logic eVld,
                              input logic [63:0] eDout, input logic [1:0] eDwsn, input logic eErr);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din; v.bw = bw; v.dwsn = dwsn;
    v.refr = refr; v.bank = bank; v.expVld = eVld; v.expDout = eDout; v.expDwsn = eDwsn; v.expErr = eErr;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic rd, input logic wr, input logic [10:0] addr, input logic [63:0] din,
                       input logic [63:0] bw, input logic [1:0] dwsn, input logic refr, input logic bank);
    bus.t1_readA  = rd;
    bus.t1_writeA = wr;
    bus.t1_addrA  = addr;
    bus.t1_dinA   = din;
    bus.t1_bwA    = bw;
    bus.t1_dwsnA  = dwsn;
    bus.t1_refrB  = refr;
    bus.t1_bankB  = bank;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 11'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_read(input string nm, input logic [1:0] eDwsn);
    logic [63:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
    chk({nm, ".vld"}, 64'(bus.rd_vld), 64'd1);
    chk({nm, ".dout"}, bus.t1_doutA, e);
    chk({nm, ".dwsn"}, 64'(bus.rd_dwsn), 64'(eDwsn));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".dout"}, bus.t1_doutA, 64'd0);
    chk({nm, ".vld"}, 64'(bus.rd_vld), 64'd0);
    chk({nm, ".dwsn"}, 64'(bus.rd_dwsn), 64'd0);
    chk({nm, ".cmd_err"}, 64'(bus.cmd_err), 64'd0);
    chk({nm, ".ref_err"}, 64'(bus.ref_err), 64'd0);
    chk({nm, ".refState"}, 64'(refState), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();

    //         name      rd wr addr   din                     bw                      dwsn refr bank  vld dout dwsn err
    vecs.push_back(mk("wr5",    0, 1, 11'd5, VA,                     ONES,                   2'd0, 0, 0,  0, 64'd0, 2'd0, 0));
    vecs.push_back(mk("rd5",    1, 0, 11'd5, 64'd0,                  64'd0,                  2'd2, 0, 0,  0, 64'd0, 2'd0, 0));
    vecs.push_back(mk("ret5",   0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  1, VA,    2'd2, 0));
    vecs.push_back(mk("hold5",  0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  0, VA,    2'd2, 0));
    vecs.push_back(mk("wrmsk",  0, 1, 11'd5, 64'h0000_0000_0000_00AB, 64'h0000_0000_0000_00FF, 2'd0, 0, 0,  0, VA,    2'd2, 0));
    vecs.push_back(mk("rd5b",   1, 0, 11'd5, 64'd0,                  64'd0,                  2'd1, 0, 0,  0, VA,    2'd2, 0));
    vecs.push_back(mk("rd5c",   1, 0, 11'd5, 64'd0,                  64'd0,                  2'd3, 0, 0,  1, VB,    2'd1, 0));
    vecs.push_back(mk("ret5c",  0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  1, VB,    2'd3, 0));
    vecs.push_back(mk("hold5c", 0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  0, VB,    2'd3, 0));
    vecs.push_back(mk("wr7",    0, 1, 11'd7, VC,                     ONES,                   2'd0, 0, 0,  0, VB,    2'd3, 0));
    vecs.push_back(mk("rw7",    1, 1, 11'd7, 64'hDEAD_BEEF_DEAD_BEEF, ONES,                   2'd1, 0, 0,  0, VB,    2'd3, 1));
    vecs.push_back(mk("rw7nx",  0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  0, VB,    2'd3, 0));
    vecs.push_back(mk("rd7",    1, 0, 11'd7, 64'd0,                  64'd0,                  2'd0, 0, 0,  0, VB,    2'd3, 0));
    vecs.push_back(mk("ret7",   0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  1, VC,    2'd0, 0));
    vecs.push_back(mk("refbad", 0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 1, 1,  0, VC,    2'd0, 1));
    vecs.push_back(mk("refbnx", 0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  0, VC,    2'd0, 0));
    vecs.push_back(mk("wr9clr", 0, 1, 11'd9, 64'd0,                  ONES,                   2'd0, 0, 0,  0, VC,    2'd0, 0));
    vecs.push_back(mk("wr9msk", 0, 1, 11'd9, 64'h0123_4567_89AB_CDEF, 64'hF0F0_F0F0_0000_FFFF, 2'd0, 0, 0,  0, VC,    2'd0, 0));
    vecs.push_back(mk("rd9",    1, 0, 11'd9, 64'd0,                  64'd0,                  2'd2, 0, 0,  0, VC,    2'd0, 0));
    vecs.push_back(mk("ret9",   0, 0, 11'd0, 64'd0,                  64'd0,                  2'd0, 0, 0,  1, VE,    2'd2, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].bw, vecs[i].dwsn,
            vecs[i].refr, vecs[i].bank);
      step();
      chk({vecs[i].name, ".vld"}, 64'(bus.rd_vld), 64'(vecs[i].expVld));
      chk({vecs[i].name, ".dout"}, bus.t1_doutA, vecs[i].expDout);
      chk({vecs[i].name, ".dwsn"}, 64'(bus.rd_dwsn), 64'(vecs[i].expDwsn));
      chk({vecs[i].name, ".cmd_err"}, 64'(bus.cmd_err), 64'(vecs[i].expErr));
    end
    idle();
    step();
    chk("table.ref_err", 64'(bus.ref_err), 64'd0);

    // refresh at T, read at T+1 is blocked (zero data), read at T+3 sees stored data
    drive(1'b0, 1'b1, 11'd0, VD, ONES, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 11'd0, 64'd0, 64'd0, 2'd0, 1'b1, 1'b0);
    step();
    chk("refr.err", 64'(bus.cmd_err), 64'd0);
    chk("refr.state", 64'(refState), 64'd1);
    drive(1'b1, 1'b0, 11'd0, 64'd0, 64'd0, 2'd1, 1'b0, 1'b0);
    exp_q.push_back(64'd0);
    step();
    chk("busyrd.err", 64'(bus.cmd_err), 64'd1);
    chk("busyrd.vld", 64'(bus.rd_vld), 64'd0);
    chk("busyrd.state", 64'(refState), 64'd1);
    idle();
    step();
    chk_read("busyret", 2'd1);
    chk("busyret.state", 64'(refState), 64'd0);
    drive(1'b1, 1'b0, 11'd0, 64'd0, 64'd0, 2'd2, 1'b0, 1'b0);
    exp_q.push_back(VD);
    step();
    chk("freerd.err", 64'(bus.cmd_err), 64'd0);
    idle();
    step();
    chk_read("freeret", 2'd2);

    // write in the same cycle as its sub-bank refresh is blocked
    drive(1'b0, 1'b1, 11'd0, 64'd0, ONES, 2'd0, 1'b1, 1'b0);
    step();
    chk("refwr.err", 64'(bus.cmd_err), 64'd1);
    idle();
    repeat (2) step();
    drive(1'b1, 1'b0, 11'd0, 64'd0, 64'd0, 2'd3, 1'b0, 1'b0);
    exp_q.push_back(VD);
    step();
    chk("refwrrd.err", 64'(bus.cmd_err), 64'd0);
    idle();
    step();
    chk_read("refwrret", 2'd3);

    // refresh on an already-busy sub-bank
    drive(1'b0, 1'b0, 11'd0, 64'd0, 64'd0, 2'd0, 1'b1, 1'b0);
    step();
    chk("ref1.err", 64'(bus.cmd_err), 64'd0);
    step();
    chk("ref2.err", 64'(bus.cmd_err), 64'd1);
    idle();
    step();
    chk("ref2nx.err", 64'(bus.cmd_err), 64'd0);
    chk("ref2nx.state", 64'(refState), 64'd1);
    repeat (2) step();
    chk("ref2end.state", 64'(refState), 64'd0);

    // reset with reads in flight
    drive(1'b1, 1'b0, 11'd5, 64'd0, 64'd0, 2'd3, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) step();
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("postrst%0d.vld", i), 64'(bus.rd_vld), 64'd0);
      chk($sformatf("postrst%0d.dout", i), bus.t1_doutA, 64'd0);
    end

    // starvation: sticky flag once a sub-bank goes REFWIN cycles without refresh
    repeat (50) step();
    chk("starv54.ref_err", 64'(bus.ref_err), 64'd0);
    repeat (20) step();
    chk("starv74.ref_err", 64'(bus.ref_err), 64'd1);
    drive(1'b0, 1'b0, 11'd0, 64'd0, 64'd0, 2'd0, 1'b1, 1'b0);
    step();
    idle();
    repeat (3) step();
    chk("starvref.ref_err", 64'(bus.ref_err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("starvrst.ref_err", 64'(bus.ref_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
